mp_add_seq: RTL
===============

# mp_add_seq

Multi-precision add/subtract sequencer. It takes two N×W-bit operands and adds them one W-bit slice per clock through a single shared rca_16bit instance (size=W). The carry between slices is held in a register. The block sits between a control master (start/done handshake) and the adder, so wide arithmetic reuses one narrow ripple-carry datapath instead of an N×W-bit chain.

## Interface
- W, 16, slice width; passed as `size` to the rca_16bit instance
- N, 4, number of slices; operand width is N*W (default 64)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  N*W  operand A; captured on accepted start
- b  in  N*W  operand B; captured on accepted start
- cin  in  1  carry-in for add; captured on accepted start
- sub  in  1  subtract request; captured on accepted start; see Configuration
- s  out  N*W  result register; reset 0
- cout  out  1  carry out of bit N*W-1; reset 0
- ovf  out  1  signed overflow of the full-width result; reset 0
- busy  out  1  high from the accepting edge until the DONE state; reset 0
- done  out  1  one-cycle pulse, result valid; reset 0

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Slice index idx is a counter of width clog2(N), at least 1 bit. Carry register is cy.
- **IDLE:**
  - start=1 latches a, b, cin and sub into internal registers.
  - Sets idx=0 and cy = sub_eff ? 1 : cin.
  - Goes to RUN and sets busy=1.
  - s, cout and ovf hold their previous values until the first RUN edge.
- **RUN, each edge:**
  - Adder inputs are A[idx], B'[idx] and cy, where B' = sub_eff ? ~b : b.
  - s[idx*W +: W] takes the adder sum, and cy takes the adder carry-out.
  - idx increments.
  - On the edge where idx==N-1:
    - cout takes the adder carry-out.
    - ovf = (A_msb ^ B'_msb ^ sum_msb) ^ carry-out, i.e. carry into the MSB XOR carry out of the MSB.
    - Next state is DONE.
- **DONE:** done=1 and busy=0 for exactly one cycle, then IDLE.
- start in RUN or DONE is ignored and not queued.
- Operand inputs may change freely after the accepting edge.
- s, cout and ovf hold until overwritten by the next operation.
- In subtract mode, cout=1 means no borrow (a ≥ b unsigned).
- Reset asserted at any time, including mid-RUN:
  - All outputs and registers clear immediately to 0 and the FSM goes to IDLE.
  - The partial result is discarded.
  - The first edge after reset deassertion samples start normally.

## Timing
- Edge 0: start accepted. busy is high after edge 0.
- Edges 1..N: slices 0..N-1 processed, one per edge.
- After edge N: done=1, busy=0, and s, cout and ovf are final.
- After edge N+1: IDLE. A new start is accepted at edge N+2 at the earliest.
- Issue interval is N+2 cycles; latency from start to done is N+1 cycles.
- The combinational path per cycle is one W-bit ripple chain plus the operand mux; there is no full-width carry path.

## Configuration
- Macro: MP_ADD_SEQ_SUB_EN.
- **Defined:** sub_eff = captured sub.
  - Subtraction computes a + ~b + 1; cin is ignored when sub=1.
  - ovf reports signed subtraction overflow.
- **Undefined:**
  - sub_eff is tied to 0 and the sub port is present but ignored.
  - No B inversion logic is synthesized; the block always computes a + b + cin.

## Test plan
All scenarios use N=4, W=16.

1. **Carry across a slice boundary.** a=0x0000_0000_0000_FFFF, b=0x1, cin=0, start → after 5 cycles done pulses one cycle with s=0x0000_0000_0001_0000, cout=0, ovf=0. busy is high for 4 cycles.
2. **Full-width carry wrap.** a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → s=0, cout=1, ovf=0.
3. **Signed overflow.** a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 → s=0x8000_0000_0000_0000, cout=0, ovf=1.
4. **Subtract, with and without the macro.** a=5, b=7, sub=1, cin=0:
   - With MP_ADD_SEQ_SUB_EN: s=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
   - Without the macro: s=0xC, cout=0.
   - With the macro, a=7, b=5, sub=1 → s=2, cout=1.
5. **start while busy.** Re-pulse start with different operands at edges 1 and 3 of an operation → the result is that of the first operation only, and exactly one done pulse occurs.
6. **Reset mid-operation.** Assert rst after edge 2 of the operation in scenario 1 → s=0, cout=0, ovf=0, busy=0, done=0 immediately, with no done pulse. After release, start a=1, b=2 → s=3 and done 5 cycles later.

Source files
------------

// File: rtl/mp_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mp_add_seq : N x W-bit add/subtract, one slice per clock via one rca_16bit |
// | Optional subtract support: define MP_ADD_SEQ_SUB_EN.  Revision 1.0        |
// +----------------------------------------------------------------------------+

module rca_16bit #(
  parameter int size = 16
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            cin,
  output logic [size-1:0] sum,
  output logic            cout
);

  logic [size:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < size; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[size];

endmodule

module mp_add_seq #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           cin,
  input  logic           sub,
  output logic [N*W-1:0] s,
  output logic           cout,
  output logic           ovf,
  output logic           busy,
  output logic           done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N*W-1:0] a_q;
  logic [N*W-1:0] b_q;
  logic [IW-1:0]  idx;
  logic           cy;

  logic [W-1:0]   a_sl;
  logic [W-1:0]   b_sl;
  logic [W-1:0]   b_op;
  logic [W-1:0]   sum;
  logic           co;
  logic           sub_now;

`ifdef MP_ADD_SEQ_SUB_EN
  logic sub_q;

  assign sub_now = sub;
  assign b_op    = sub_q ? ~b_sl : b_sl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sub_q <= sub;
    end
  end
`else
  // Port kept for a uniform interface; nothing downstream observes it.
  logic unused_sub;

  assign unused_sub = sub;
  assign sub_now    = 1'b0;
  assign b_op       = b_sl;
`endif

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*W +: W];
        b_sl = b_q[i*W +: W];
      end
    end
  end

  rca_16bit #(
    .size(W)
  ) u_rca (
    .a   (a_sl),
    .b   (b_op),
    .cin (cy),
    .sum (sum),
    .cout(co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      cy    <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            // Subtraction's +1 rides in as the slice-0 carry.
            cy    <= sub_now ? 1'b1 : cin;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
              s[i*W +: W] <= sum;
            end
          end
          cy  <= co;
          idx <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            cout  <= co;
            // a^b^sum at the MSB recovers the carry into it.
            ovf   <= a_sl[W-1] ^ b_op[W-1] ^ sum[W-1] ^ co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
